cv32e40p_trace_buffer: RTL and testbench



---
 rtl/cv32e40p_trace_pkg.sv | 19 +
 rtl/cv32e40p_trace_fifo.sv | 110 +++++++++++
 rtl/cv32e40p_trace_buffer.sv | 176 +++++++++++++++++
 tb/tb_cv32e40p_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_trace_pkg.sv
// Shared types and constants for the retired-instruction trace buffer.
package cv32e40p_trace_pkg;

    localparam int TRACE_TS_W = 32;
    localparam int DROP_CNT_W = 16;
    localparam int TRACE_CH_W = 3;

    typedef struct packed {
        logic [TRACE_CH_W-1:0] ch;
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [TRACE_TS_W-1:0] ts;
    } trace_rec_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cv32e40p_trace_fifo.sv
// First-word-fall-through FIFO of trace records; head is held in a register
// so the storage array only needs a registered read port.
module cv32e40p_trace_fifo
    import cv32e40p_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter bit TS_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  trace_rec_t               push_rec,
    input  logic                     pop,
    output trace_rec_t               head_rec,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CORE_W = TRACE_CH_W + 64;

    logic [CORE_W-1:0]     mem_core [DEPTH];
    logic [CORE_W-1:0]     head_core_reg;
    logic [CORE_W-1:0]     push_core;
    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_next_addr;
    logic                  do_push;
    logic                  do_pop;
    logic                  load_push;
    logic                  load_mem;
    logic [TRACE_TS_W-1:0] head_ts;

    assign push_core    = {push_rec.ch, push_rec.pc, push_rec.instr};
    assign level        = wr_ptr_reg - rd_ptr_reg;
    assign empty        = (wr_ptr_reg == rd_ptr_reg);
    assign full         = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
    assign do_pop       = pop & ~empty;
    assign do_push      = push & (~full | do_pop);
    assign wr_addr      = wr_ptr_reg[AW-1:0];
    assign rd_next_addr = rd_ptr_reg[AW-1:0] + AW'(1);

    // The incoming record bypasses the array when it becomes the head right away
    assign load_push = do_push & (empty | (do_pop & (level == (AW+1)'(1))));
    assign load_mem  = do_pop & (level > (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_core[wr_addr] <= push_core;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            head_core_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            if (load_push) begin
                head_core_reg <= push_core;
            end else if (load_mem) begin
                head_core_reg <= mem_core[rd_next_addr];
            end
        end
    end

    generate
        if (TS_EN) begin : g_ts
            logic [TRACE_TS_W-1:0] mem_ts [DEPTH];
            logic [TRACE_TS_W-1:0] head_ts_reg;

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem_ts[wr_addr] <= push_rec.ts;
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    head_ts_reg <= '0;
                end else if (load_push) begin
                    head_ts_reg <= push_rec.ts;
                end else if (load_mem) begin
                    head_ts_reg <= mem_ts[rd_next_addr];
                end
            end

            assign head_ts = head_ts_reg;
        end else begin : g_no_ts
            logic unused_ts;
            assign unused_ts = ^push_rec.ts;
            assign head_ts   = '0;
        end
    endgenerate

    always_comb begin
        head_rec = '0;
        {head_rec.ch, head_rec.pc, head_rec.instr} = head_core_reg;
        head_rec.ts = head_ts;
    end

endmodule

// File: rtl/cv32e40p_trace_buffer.sv
// Multi-channel retire trace buffer: per-channel holding registers, round-robin
// merge into one FIFO, saturating drop counters. Timestamps: CV32E40P_TRACE_TIMESTAMP_EN.
module cv32e40p_trace_buffer
    import cv32e40p_trace_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_CH-1:0]                  ch_valid_i,
    input  logic [NUM_CH-1:0][31:0]            ch_pc_i,
    input  logic [NUM_CH-1:0][31:0]            ch_instr_i,
    output logic [NUM_CH-1:0]                  ch_ready_o,
    output logic                               rec_valid_o,
    input  logic                               rec_ready_i,
    output logic [CH_W-1:0]                    rec_ch_o,
    output logic [31:0]                        rec_pc_o,
    output logic [31:0]                        rec_instr_o,
    output logic [31:0]                        rec_ts_o,
    output logic [$clog2(DEPTH):0]             level_o,
    input  logic                               drop_clr_i,
    output logic [NUM_CH-1:0][DROP_CNT_W-1:0]  drop_cnt_o
);

    logic [NUM_CH-1:0]                 hold_vld;
    logic [NUM_CH-1:0][31:0]           hold_pc;
    logic [NUM_CH-1:0][31:0]           hold_instr;
    logic [NUM_CH-1:0][TRACE_TS_W-1:0] hold_ts;
    logic [NUM_CH-1:0]                 capture;
    logic [NUM_CH-1:0]                 grant;
    logic [CH_W-1:0]                   last_gnt_reg;
    logic [CH_W-1:0]                   gnt_idx;
    logic [CH_W-1:0]                   cand_idx;
    int                                cand;
    logic                              gnt_any;
    logic                              push_ok;
    logic                              pop;
    logic                              fifo_full;
    logic                              fifo_empty;
    trace_rec_t                        push_rec;
    trace_rec_t                        head_rec;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                  hold_vld_reg;
        logic [31:0]           hold_pc_reg;
        logic [31:0]           hold_instr_reg;
        logic [DROP_CNT_W-1:0] drop_cnt_reg;

        // A holding register being granted this cycle can reload in the same cycle
        assign ch_ready_o[gi] = ~hold_vld_reg | grant[gi];
        assign capture[gi]    = ch_valid_i[gi] & ch_ready_o[gi];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                hold_vld_reg   <= 1'b0;
                hold_pc_reg    <= '0;
                hold_instr_reg <= '0;
                drop_cnt_reg   <= '0;
            end else begin
                if (capture[gi]) begin
                    hold_vld_reg   <= 1'b1;
                    hold_pc_reg    <= ch_pc_i[gi];
                    hold_instr_reg <= ch_instr_i[gi];
                end else if (grant[gi]) begin
                    hold_vld_reg <= 1'b0;
                end
                if (drop_clr_i) begin
                    drop_cnt_reg <= '0;
                end else if (ch_valid_i[gi] & ~ch_ready_o[gi]) begin
                    drop_cnt_reg <= sat_inc(drop_cnt_reg);
                end
            end
        end

        assign hold_vld[gi]   = hold_vld_reg;
        assign hold_pc[gi]    = hold_pc_reg;
        assign hold_instr[gi] = hold_instr_reg;
        assign drop_cnt_o[gi] = drop_cnt_reg;
    end

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    logic [TRACE_TS_W-1:0] ts_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TRACE_TS_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hold_ts
        logic [TRACE_TS_W-1:0] hold_ts_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                hold_ts_reg <= '0;
            end else if (capture[gi]) begin
                hold_ts_reg <= ts_reg;
            end
        end

        assign hold_ts[gi] = hold_ts_reg;
    end

    assign rec_ts_o = head_rec.ts;
`else
    localparam bit TS_EN = 1'b0;
    assign hold_ts  = '0;
    assign rec_ts_o = 32'h0;
`endif

    assign pop     = rec_valid_o & rec_ready_i;
    assign push_ok = ~fifo_full | pop;

    // Round-robin: search starts one past the last granted channel
    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        push_rec = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = int'(last_gnt_reg) + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = CH_W'(cand);
            if (!gnt_any && push_ok && hold_vld[cand_idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = cand_idx;
                grant[cand_idx] = 1'b1;
                push_rec.ch     = TRACE_CH_W'(cand_idx);
                push_rec.pc     = hold_pc[cand_idx];
                push_rec.instr  = hold_instr[cand_idx];
                push_rec.ts     = hold_ts[cand_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_reg <= CH_W'(NUM_CH - 1);
        end else if (gnt_any) begin
            last_gnt_reg <= gnt_idx;
        end
    end

    cv32e40p_trace_fifo #(
        .DEPTH (DEPTH),
        .TS_EN (TS_EN)
    ) u_fifo (
        .clk      (clk_i),
        .srst     (rst_i),
        .push     (gnt_any),
        .push_rec (push_rec),
        .pop      (pop),
        .head_rec (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    logic unused_head;
    assign unused_head = ^{head_rec.ch, head_rec.ts};

    assign rec_valid_o = ~fifo_empty;
    assign rec_ch_o    = head_rec.ch[CH_W-1:0];
    assign rec_pc_o    = head_rec.pc;
    assign rec_instr_o = head_rec.instr;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Scoreboard bench for the trace buffer: expected records queued at stimulus, observed records logged at pop.
`timescale 1ns/1ps
module tb_cv32e40p_trace_buffer;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int CH_W   = 2;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [31:0]     ts;
    } rec_t;

    logic                        clk = 1'b0;
    logic                        rst_i = 1'b1;
    logic [NUM_CH-1:0]           ch_valid = '0;
    logic [NUM_CH-1:0][31:0]     ch_pc = '0;
    logic [NUM_CH-1:0][31:0]     ch_instr = '0;
    logic [NUM_CH-1:0]           ch_ready_o;
    logic                        rec_valid_o;
    logic                        rec_ready = 1'b0;
    logic [CH_W-1:0]             rec_ch_o;
    logic [31:0]                 rec_pc_o;
    logic [31:0]                 rec_instr_o;
    logic [31:0]                 rec_ts_o;
    logic [$clog2(DEPTH):0]      level_o;
    logic                        drop_clr = 1'b0;
    logic [NUM_CH-1:0][15:0]     drop_cnt_o;

    rec_t        exp_q[$];
    rec_t        obs_mem [1024];
    rec_t        exp_r;
    rec_t        got_r;
    int          obs_wr = 0;
    int          obs_rd = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    cv32e40p_trace_buffer #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ch_valid_i  (ch_valid),
        .ch_pc_i     (ch_pc),
        .ch_instr_i  (ch_instr),
        .ch_ready_o  (ch_ready_o),
        .rec_valid_o (rec_valid_o),
        .rec_ready_i (rec_ready),
        .rec_ch_o    (rec_ch_o),
        .rec_pc_o    (rec_pc_o),
        .rec_instr_o (rec_instr_o),
        .rec_ts_o    (rec_ts_o),
        .level_o     (level_o),
        .drop_clr_i  (drop_clr),
        .drop_cnt_o  (drop_cnt_o)
    );

    // Cycle index since reset, matching the timestamp the buffer should capture
    always @(posedge clk) cyc <= rst_i ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!rst_i && rec_valid_o && rec_ready) begin
            obs_mem[obs_wr % 1024] <= '{rec_ch_o, rec_pc_o, rec_instr_o, rec_ts_o};
            obs_wr <= obs_wr + 1;
            $display("rec ch=%0d pc=%h instr=%h ts=%0d", rec_ch_o, rec_pc_o, rec_instr_o, rec_ts_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; ch_valid = '0; rec_ready = 1'b0; drop_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        obs_rd = obs_wr;
        exp_q.delete();
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && (obs_wr - obs_rd) < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rec_valid_o); end
        checks++; if (level_o !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
        checks++; if (ch_ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready got %h want f", ch_ready_o); end
        checks++; if (drop_cnt_o !== '0) begin errors++; $display("FAIL reset_drop got %h want 0", drop_cnt_o); end
        checks++; if ({rec_ch_o, rec_pc_o, rec_instr_o, rec_ts_o} !== '0) begin
            errors++; $display("FAIL reset_data got ch=%0d pc=%h instr=%h ts=%h want 0", rec_ch_o, rec_pc_o, rec_instr_o, rec_ts_o);
        end
    endtask

    task automatic test_single();
        rec_ready = 1'b1;
        while (cyc != 5) step();
        ch_valid = 4'b0001; ch_pc[0] = 32'h1000; ch_instr[0] = 32'h0000_0013;
        exp_q.push_back('{2'd0, 32'h1000, 32'h13, TS_ON ? 32'd5 : 32'd0});
        step();
        ch_valid = '0;
        checks++; if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rec_valid_o); end
        step();
        checks++; if (rec_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", rec_valid_o); end
        wait_obs(exp_q.size(), 50);
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin errors++; $display("FAIL single_count got %0d want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd != obs_wr) begin
            exp_r = exp_q.pop_front(); got_r = obs_mem[obs_rd % 1024]; obs_rd++;
            checks++; if (got_r !== exp_r) begin errors++; $display("FAIL single_rec got %h want %h", got_r, exp_r); end
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        do_reset();
        rec_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                ch_pc[c] = 32'h2000 + 32'(b * 256 + c * 4);
                ch_instr[c] = $urandom;
                exp_q.push_back('{CH_W'(c), ch_pc[c], ch_instr[c], TS_ON ? cyc : 32'd0});
            end
            ch_valid = '1;
            step();
            ch_valid = '0;
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (rec_valid_o !== 1'b1 || rec_ch_o !== CH_W'(c)) begin
                    errors++; $display("FAIL rr_order burst %0d got valid=%b ch=%0d want valid=1 ch=%0d", b, rec_valid_o, rec_ch_o, c);
                end
                step();
            end
        end
        wait_obs(exp_q.size(), 50);
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin errors++; $display("FAIL rr_count got %0d want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd != obs_wr) begin
            exp_r = exp_q.pop_front(); got_r = obs_mem[obs_rd % 1024]; obs_rd++;
            checks++; if (got_r !== exp_r) begin errors++; $display("FAIL rr_rec got %h want %h", got_r, exp_r); end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        do_reset();
        step();
        ch_valid = 4'b0001;
        for (int k = 0; k < 22; k++) begin
            ch_pc[0] = 32'h4000 + 32'(k * 4);
            ch_instr[0] = 32'h1000_0000 + 32'(k);
            if (k < DEPTH + 1) exp_q.push_back('{2'd0, ch_pc[0], ch_instr[0], TS_ON ? cyc : 32'd0});
            if (k == DEPTH + 1) begin
                checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL bp_full_level got %0d want 16", level_o); end
                checks++; if (ch_ready_o[0] !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", ch_ready_o[0]); end
            end
            if (k >= DEPTH + 1) begin
                checks++;
                if (drop_cnt_o[0] !== 16'(k - DEPTH - 1)) begin
                    errors++; $display("FAIL bp_drop got %0d want %0d", drop_cnt_o[0], k - DEPTH - 1);
                end
            end
            step();
        end
        ch_valid = '0;
        checks++; if (drop_cnt_o[0] !== 16'd5) begin errors++; $display("FAIL bp_drop_total got %0d want 5", drop_cnt_o[0]); end
        // Full FIFO: pop and push in the same cycle, new retire must be accepted
        ch_valid = 4'b0001; ch_pc[0] = 32'h5000; ch_instr[0] = 32'h5555_0001; rec_ready = 1'b1;
        exp_q.push_back('{2'd0, 32'h5000, 32'h5555_0001, TS_ON ? cyc : 32'd0});
        step();
        ch_valid = '0;
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL bp_pushpop_level got %0d want 16", level_o); end
        checks++; if (drop_cnt_o[0] !== 16'd5) begin errors++; $display("FAIL bp_pushpop_drop got %0d want 5", drop_cnt_o[0]); end
        wait_obs(exp_q.size(), 100);
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd != obs_wr) begin
            exp_r = exp_q.pop_front(); got_r = obs_mem[obs_rd % 1024]; obs_rd++;
            checks++; if (got_r !== exp_r) begin errors++; $display("FAIL bp_rec got %h want %h", got_r, exp_r); end
        end
        exp_q.delete();
        checks++; if (level_o !== '0) begin errors++; $display("FAIL bp_drained_level got %0d want 0", level_o); end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        step();
        ch_valid = 4'b0001;
        repeat (DEPTH + 1) step();
        ch_valid = 4'b0010;
        step();
        repeat (65534) step();
        checks++; if (drop_cnt_o[1] !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", drop_cnt_o[1]); end
        step();
        checks++; if (drop_cnt_o[1] !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", drop_cnt_o[1]); end
        step();
        checks++; if (drop_cnt_o[1] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", drop_cnt_o[1]); end
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        checks++; if (drop_cnt_o[1] !== 16'h0) begin errors++; $display("FAIL sat_clr got %h want 0", drop_cnt_o[1]); end
        step();
        checks++; if (drop_cnt_o[1] !== 16'h1) begin errors++; $display("FAIL sat_after_clr got %h want 1", drop_cnt_o[1]); end
        ch_valid = '0;
    endtask

    task automatic test_mid_reset();
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL mid_pre_level got %0d want 16", level_o); end
        rst_i = 1'b1;
        step();
        checks++; if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", rec_valid_o); end
        checks++; if (level_o !== '0) begin errors++; $display("FAIL mid_level got %0d want 0", level_o); end
        checks++; if (drop_cnt_o !== '0) begin errors++; $display("FAIL mid_drop got %h want 0", drop_cnt_o); end
        rst_i = 1'b0;
        obs_rd = obs_wr;
        exp_q.delete();
        rec_ready = 1'b1;
        step();
        ch_valid = 4'b1000; ch_pc[3] = 32'h9000; ch_instr[3] = 32'h0010_0093;
        exp_q.push_back('{2'd3, 32'h9000, 32'h0010_0093, TS_ON ? cyc : 32'd0});
        step();
        ch_valid = '0;
        repeat (8) step();
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin errors++; $display("FAIL mid_count got %0d want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd != obs_wr) begin
            exp_r = exp_q.pop_front(); got_r = obs_mem[obs_rd % 1024]; obs_rd++;
            checks++; if (got_r !== exp_r) begin errors++; $display("FAIL mid_rec got %h want %h", got_r, exp_r); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drop_saturate();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
